power_sequencer: RTL

Computes an integer power baseⁿ of a decimal floating-point operand by sequencing one shared `multiplier` instance with right-to-left square-and-multiply. Operands use the calculator's number format: sign bit, 34-bit unsigned mantissa (max 17179869183) and 7-bit signed decimal exponent. The block sits between the calculator's operation decoder and the multiplier. It drives the multiplier's operand and eval inputs and consumes its done and result outputs.

---
 rtl/power_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/power_sequencer.sv
// power_sequencer
//
// Computes base**n for a calculator-format decimal floating-point operand
// (sign, 34-bit unsigned mantissa, 7-bit signed decimal exponent). It uses
// right-to-left square-and-multiply and sequences one shared external
// multiplier.
//
// Ports
//   clock, reset                 system clock, asynchronous active-high reset
//   start                        request; rising edge accepted only when idle
//   baseSign/baseMant/baseExp    base operand, sampled on the accepted edge
//   power                        unsigned exponent n, sampled on the accepted edge
//   busy                         high while a computation is in flight
//   done                         one-cycle completion pulse
//   error                        exponent-range abort flag, valid with done
//   resSign/resMant/resExp       result, held until the next completion
//   mulEval                      multiplier evaluate request
//   mulSignA/mulMantA/mulExpA    multiplier operand A
//   mulSignB/mulMantB/mulExpB    multiplier operand B
//   mulDone                      multiplier completion pulse
//   mulSignRes/mulMantRes/mulExpRes  multiplier product
module power_sequencer #(
    parameter int POW_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                baseSign,
    input  logic [33:0]         baseMant,
    input  logic signed [6:0]   baseExp,
    input  logic [POW_W-1:0]    power,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                resSign,
    output logic [33:0]         resMant,
    output logic signed [6:0]   resExp,
    output logic                mulEval,
    output logic                mulSignA,
    output logic [33:0]         mulMantA,
    output logic signed [6:0]   mulExpA,
    output logic                mulSignB,
    output logic [33:0]         mulMantB,
    output logic signed [6:0]   mulExpB,
    input  logic                mulDone,
    input  logic                mulSignRes,
    input  logic [33:0]         mulMantRes,
    input  logic signed [6:0]   mulExpRes
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_FIN,
        S_ERR
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_SQR
    } op_t;

    state_t state, state_next;
    op_t    op, op_next;
    logic   start_q;
    logic   start_edge;

    // Working registers: R (running result), A (running square), E (bits left)
    logic               r_sign;
    logic [33:0]        r_mant;
    logic signed [6:0]  r_exp;
    logic               a_sign;
    logic [33:0]        a_mant;
    logic signed [6:0]  a_exp;
    logic [POW_W-1:0]   e_reg;

    // Selected operand A: R for a multiply step, A for a squaring step.
    // Operand B is always the running square A.
    logic               opa_sign;
    logic [33:0]        opa_mant;
    logic signed [6:0]  opa_exp;
    logic signed [8:0]  exp_sum;
    logic               range_bad;

    // Sign-extend a 7-bit exponent so the sum of two cannot wrap.
    function automatic logic signed [8:0] ext9(input logic signed [6:0] x);
        return {{2{x[6]}}, x};
    endfunction

    assign start_edge = start & ~start_q;

    assign opa_sign = (op == OP_MUL) ? r_sign : a_sign;
    assign opa_mant = (op == OP_MUL) ? r_mant : a_mant;
    assign opa_exp  = (op == OP_MUL) ? r_exp  : a_exp;

    assign exp_sum = ext9(opa_exp) + ext9(a_exp);

    // Upper limit 52 leaves room for the up to 11 decimal normalisation
    // steps the multiplier may add to a 68-bit product. A zero mantissa
    // always yields zero, so it never counts as out of range.
    assign range_bad = (opa_mant != 34'd0) && (a_mant != 34'd0) &&
                       ((exp_sum > 9'sd52) || (exp_sum < -9'sd64));

    // Next-state logic and multiplier interface
    always_comb begin
        state_next = state;
        op_next    = op;
        mulEval    = 1'b0;
        mulSignA   = 1'b0;
        mulMantA   = 34'd0;
        mulExpA    = 7'sd0;
        mulSignB   = 1'b0;
        mulMantB   = 34'd0;
        mulExpB    = 7'sd0;

        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                if (e_reg == '0) begin
                    state_next = S_FIN;
                end else if (e_reg[0]) begin
                    op_next    = OP_MUL;
                    state_next = S_CHECK;
                end else begin
                    op_next    = OP_SQR;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = range_bad ? S_ERR : S_ISSUE;
            end
            S_ISSUE, S_WAIT: begin
                // Operands and eval stay stable until the multiplier answers.
                mulEval  = 1'b1;
                mulSignA = opa_sign;
                mulMantA = opa_mant;
                mulExpA  = opa_exp;
                mulSignB = a_sign;
                mulMantB = a_mant;
                mulExpB  = a_exp;
                if (state == S_ISSUE) begin
                    state_next = S_WAIT;
                end else if (mulDone) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                // One low cycle on mulEval gives the multiplier a fresh edge.
                state_next = S_STEP;
            end
            S_FIN, S_ERR: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control and visible outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            op      <= OP_MUL;
            start_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            resSign <= 1'b0;
            resMant <= 34'd0;
            resExp  <= 7'sd0;
        end else begin
            state   <= state_next;
            op      <= op_next;
            start_q <= start;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        busy <= 1'b1;
                    end
                end
                S_FIN: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    error   <= 1'b0;
                    resSign <= r_sign;
                    resMant <= r_mant;
                    resExp  <= r_exp;
                end
                S_ERR: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    error   <= 1'b1;
                    resSign <= 1'b0;
                    resMant <= 34'd0;
                    resExp  <= 7'sd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Working registers; always loaded on an accepted start before use
    always_ff @(posedge clock) begin
        if (state == S_IDLE && start_edge) begin
            r_sign <= 1'b0;
            r_mant <= 34'd1;
            r_exp  <= 7'sd0;
            a_sign <= baseSign;
            a_mant <= baseMant;
            a_exp  <= baseExp;
            e_reg  <= power;
        end else if (state == S_WAIT && mulDone) begin
            if (op == OP_MUL) begin
                r_sign <= mulSignRes;
                r_mant <= mulMantRes;
                r_exp  <= mulExpRes;
                e_reg  <= {e_reg[POW_W-1:1], 1'b0};
            end else begin
                a_sign <= mulSignRes;
                a_mant <= mulMantRes;
                a_exp  <= mulExpRes;
                e_reg  <= e_reg >> 1;
            end
        end
    end

endmodule
